// File: rtl/valu_seq.sv
// Vector ALU sequencer: latches a vector op on start, processes one element per step
// (multiply elements take MUL_LAT cycles on one shared multiplier), then pulses done.
//
// state | meaning
// IDLE  | waiting for start; elem_idx held at 0
// EXEC  | one add/sub/logic element per cycle
// MUL   | one multiply element every MUL_LAT cycles
// DONE  | done pulse, results final
// ERR   | done+err pulse, results left at zero
module valu_seq #(
    parameter int NLANES  = 5,
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [2:0]               vlen,
    input  logic [2:0]               alu_ctrl,
    input  logic [NLANES*WIDTH-1:0]  a_flat,
    input  logic [NLANES*WIDTH-1:0]  b_flat,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [2:0]               elem_idx,
    output logic [NLANES*WIDTH-1:0]  result_flat
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_MUL,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b110;

    localparam logic [2:0] NLANES_3 = 3'(NLANES);
    localparam logic [2:0] MUL_LAST = 3'(MUL_LAT - 1);

    state_t             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [2:0]         vlen_q, vlen_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q [NLANES];
    logic [WIDTH-1:0]   a_d [NLANES];
    logic [WIDTH-1:0]   b_q [NLANES];
    logic [WIDTH-1:0]   b_d [NLANES];
    logic [WIDTH-1:0]   res_q [NLANES];
    logic [WIDTH-1:0]   res_d [NLANES];

    logic [WIDTH-1:0]   a_cur, b_cur, alu_out, mul_lo;
    logic               last_elem, req_bad;

    assign a_cur     = a_q[idx_q];
    assign b_cur     = b_q[idx_q];
    assign last_elem = (idx_q == vlen_q - 3'd1);
    assign req_bad   = (vlen == 3'd0) || (vlen > NLANES_3)
                       || (alu_ctrl == 3'b101) || (alu_ctrl == 3'b111);
    // Truncating WIDTH x WIDTH product keeps exactly the low WIDTH bits.
    assign mul_lo    = a_cur * b_cur;

    always_comb begin
        alu_out = '0;
        case (op_q)
            OP_ADD:  alu_out = a_cur + b_cur;
            OP_SUB:  alu_out = a_cur + ~b_cur + 1'b1;
            OP_AND:  alu_out = a_cur & b_cur;
            OP_OR:   alu_out = a_cur | b_cur;
            OP_XOR:  alu_out = a_cur ^ b_cur;
            default: alu_out = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        vlen_d  = vlen_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                idx_d = '0;
                cnt_d = '0;
                if (start) begin
                    vlen_d = vlen;
                    op_d   = alu_ctrl;
                    for (int k = 0; k < NLANES; k++) begin
                        a_d[k]   = a_flat[k*WIDTH +: WIDTH];
                        b_d[k]   = b_flat[k*WIDTH +: WIDTH];
                        res_d[k] = '0;
                    end
                    if (req_bad)                 state_d = S_ERR;
                    else if (alu_ctrl == OP_MUL) state_d = S_MUL;
                    else                         state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                res_d[idx_q] = alu_out;
                if (last_elem) state_d = S_DONE;
                else           idx_d   = idx_q + 3'd1;
            end
            S_MUL: begin
                if (cnt_q == MUL_LAST) begin
                    cnt_d        = '0;
                    res_d[idx_q] = mul_lo;
                    if (last_elem) state_d = S_DONE;
                    else           idx_d   = idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_DONE, S_ERR: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            vlen_q  <= '0;
            op_q    <= '0;
            a_q     <= '{default: '0};
            b_q     <= '{default: '0};
            res_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            vlen_q  <= vlen_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    assign busy     = (state_q == S_EXEC) || (state_q == S_MUL);
    assign done     = (state_q == S_DONE) || (state_q == S_ERR);
    assign err      = (state_q == S_ERR);
    assign elem_idx = idx_q;

    always_comb begin
        result_flat = '0;
        for (int k = 0; k < NLANES; k++) result_flat[k*WIDTH +: WIDTH] = res_q[k];
    end

endmodule

// File: tb/tb_valu_seq.sv
// Directed bench for valu_seq: vector table of ops with hand-computed results and
// cycle counts, plus hand sequences for reset, ignored start and reset mid-multiply.
module tb_valu_seq;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   vlen;
    logic [2:0]   alu_ctrl;
    logic [159:0] a_flat, b_flat;
    logic         busy, done, err;
    logic [2:0]   elem_idx;
    logic [159:0] result_flat;

    int total = 0;
    int bad   = 0;

    valu_seq #(.NLANES(5), .WIDTH(32), .MUL_LAT(3)) dut (
        .clk(clk), .reset(reset), .start(start), .vlen(vlen), .alu_ctrl(alu_ctrl),
        .a_flat(a_flat), .b_flat(b_flat), .busy(busy), .done(done), .err(err),
        .elem_idx(elem_idx), .result_flat(result_flat)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]   vlen;
        logic [2:0]   op;
        logic [159:0] a;
        logic [159:0] b;
        logic [159:0] exp;
        logic [7:0]   done_c;
        logic [7:0]   busy_c;
        logic         err;
    } vec_t;

    vec_t vecs [11];

    function automatic logic [159:0] p5(input logic [31:0] e0, e1, e2, e3, e4);
        return {e4, e3, e2, e1, e0};
    endfunction

    function automatic vec_t mk(input logic [2:0] vl, input logic [2:0] op,
                                input logic [159:0] a, input logic [159:0] b,
                                input logic [159:0] exp, input int dc, input int bc,
                                input logic e);
        vec_t v;
        v.vlen = vl; v.op = op; v.a = a; v.b = b; v.exp = exp;
        v.done_c = 8'(dc); v.busy_c = 8'(bc); v.err = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input int poke, input string tag);
        int busy_n, done_cyc;
        logic err_s;
        logic [2:0] idx_s;
        logic [159:0] res_s;
        busy_n = 0; done_cyc = -1; err_s = 1'b0; idx_s = '0; res_s = '0;
        @(posedge clk); #1;
        vlen = v.vlen; alu_ctrl = v.op; a_flat = v.a; b_flat = v.b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        vlen = 3'($urandom); alu_ctrl = 3'($urandom);
        a_flat = {$urandom, $urandom, $urandom, $urandom, $urandom};
        b_flat = {$urandom, $urandom, $urandom, $urandom, $urandom};
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                done_cyc = cyc; err_s = err; idx_s = elem_idx; res_s = result_flat;
                break;
            end
            if (cyc == poke) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk({tag, " done_cycle"}, 160'(done_cyc), 160'(v.done_c));
        chk({tag, " busy_cycles"}, 160'(busy_n), 160'(v.busy_c));
        chk({tag, " err"}, 160'(err_s), 160'(v.err));
        chk({tag, " result"}, res_s, v.exp);
        chk({tag, " idx_at_done"}, 160'(idx_s), v.err ? 160'(0) : 160'(v.vlen - 3'd1));
        @(negedge clk);
        chk({tag, " idle_after"}, 160'({done, busy, err, elem_idx}), 160'(0));
        chk({tag, " result_hold"}, result_flat, v.exp);
    endtask

    initial begin
        vecs[0]  = mk(3'd5, 3'b000, p5(1, 2, 3, 4, 32'hFFFF_FFFF), p5(10, 20, 30, 40, 1),
                      p5(11, 22, 33, 44, 0), 6, 5, 1'b0);
        vecs[1]  = mk(3'd3, 3'b001, p5(5, 0, 7, 9, 9), p5(3, 1, 7, 9, 9),
                      p5(2, 32'hFFFF_FFFF, 0, 0, 0), 4, 3, 1'b0);
        vecs[2]  = mk(3'd2, 3'b110, p5(6, 32'h1_0000, 5, 5, 5), p5(7, 32'h1_0000, 5, 5, 5),
                      p5(42, 0, 0, 0, 0), 7, 6, 1'b0);
        vecs[3]  = mk(3'd0, 3'b000, p5(1, 2, 3, 4, 5), p5(1, 2, 3, 4, 5), '0, 1, 0, 1'b1);
        vecs[4]  = mk(3'd2, 3'b101, p5(1, 2, 3, 4, 5), p5(1, 2, 3, 4, 5), '0, 1, 0, 1'b1);
        vecs[5]  = mk(3'd6, 3'b000, p5(1, 2, 3, 4, 5), p5(1, 2, 3, 4, 5), '0, 1, 0, 1'b1);
        vecs[6]  = mk(3'd2, 3'b010, p5(32'hF0F0, 32'hFFFF, 1, 1, 1),
                      p5(32'hFF00, 32'h0F0F, 1, 1, 1), p5(32'hF000, 32'h0F0F, 0, 0, 0), 3, 2, 1'b0);
        vecs[7]  = mk(3'd4, 3'b011, p5(1, 2, 4, 8, 7), p5(32'h10, 32'h20, 32'h40, 32'h80, 7),
                      p5(32'h11, 32'h22, 32'h44, 32'h88, 0), 5, 4, 1'b0);
        vecs[8]  = mk(3'd5, 3'b100, p5(32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'hFFFF_0000),
                      p5(32'h5555_5555, 32'h5555_5555, 32'h5555_5555, 32'h5555_5555, 32'hFFFF_FFFF),
                      p5(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF), 6, 5, 1'b0);
        vecs[9]  = mk(3'd5, 3'b110, p5(3, 32'hFFFF_FFFF, 0, 32'h12345, 1),
                      p5(5, 2, 9, 32'h10, 32'hDEAD_BEEF),
                      p5(15, 32'hFFFF_FFFE, 0, 32'h123450, 32'hDEAD_BEEF), 16, 15, 1'b0);
        vecs[10] = mk(3'd1, 3'b111, p5(1, 2, 3, 4, 5), p5(1, 2, 3, 4, 5), '0, 1, 0, 1'b1);

        // reset held with random inputs, including start
        reset = 1'b0; start = 1'b1;
        vlen = 3'($urandom); alu_ctrl = 3'($urandom);
        a_flat = {$urandom, $urandom, $urandom, $urandom, $urandom};
        b_flat = {$urandom, $urandom, $urandom, $urandom, $urandom};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst busy", 160'(busy), 160'(0));
        chk("rst done", 160'(done), 160'(0));
        chk("rst err", 160'(err), 160'(0));
        chk("rst elem_idx", 160'(elem_idx), 160'(0));
        chk("rst result", result_flat, '0);
        start = 1'b0;
        reset = 1'b1;
        begin
            logic act;
            act = 1'b0;
            repeat (6) begin
                @(negedge clk);
                if (busy || done || err || (result_flat != '0)) act = 1'b1;
            end
            chk("no activity without start", 160'(act), 160'(0));
        end

        for (int i = 0; i < 11; i++) run_op(vecs[i], 0, $sformatf("vec%0d", i));

        // start pulsed mid-operation must be ignored
        run_op(vecs[0], 2, "poke_add");
        run_op(vecs[2], 4, "poke_mul");

        // reset during multiply element 1
        begin
            logic found, act;
            found = 1'b0; act = 1'b0;
            @(posedge clk); #1;
            vlen = vecs[2].vlen; alu_ctrl = vecs[2].op;
            a_flat = vecs[2].a; b_flat = vecs[2].b; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (busy && elem_idx == 3'd1) begin found = 1'b1; break; end
            end
            chk("midrst reached elem1", 160'(found), 160'(1));
            reset = 1'b0;
            #1;
            chk("midrst outputs", 160'({busy, done, err, elem_idx}), 160'(0));
            chk("midrst result", result_flat, '0);
            repeat (2) @(posedge clk);
            #1 reset = 1'b1;
            repeat (5) begin
                @(negedge clk);
                if (done || busy) act = 1'b1;
            end
            chk("midrst no done", 160'(act), 160'(0));
        end
        run_op(mk(3'd1, 3'b100, p5(32'hF0F0, 1, 1, 1, 1), p5(32'hFF00, 2, 2, 2, 2),
                  p5(32'h0FF0, 0, 0, 0, 0), 2, 1, 1'b0), 0, "post_rst_xor");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
